// File: rtl/resource_arb_pkg.sv
// Shared defaults and helpers for the round-robin resource arbiter.
package resource_arb_pkg;
  localparam int MAX_REQ     = 8;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int RES_LAT_DEF = 2;
  localparam int TAG_W_DEF   = $clog2(NUM_REQ_DEF);

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin scan: first eligible index at or after ptr, wrapping.
module rr_picker
  import resource_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [TAG_W-1:0]   ptr,
  output logic               found,
  output logic [TAG_W-1:0]   win_idx,
  output logic [NUM_REQ-1:0] win_oh
);
  int               j;
  logic [TAG_W-1:0] idx;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // explicit wrap so non-power-of-2 requester counts stay in range
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = TAG_W'(j);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    win_oh = found ? NUM_REQ'(onehot(3'(win_idx))) : '0;
  end
endmodule

// File: rtl/resource_arbiter.sv
// Round-robin arbiter in front of a fixed-latency shared resource; results are
// routed back to the issuing requester through a tag shift register.
module resource_arbiter
  import resource_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_LAT = RES_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         res_in,
  output logic                      res_in_valid,
  input  logic [DATA_W-1:0]         res_out,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid
);
  localparam int TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]             ptr, win_idx, res_tag;
  logic                         found;
  logic [NUM_REQ-1:0]           elig, win_oh, tail_oh;
  logic [RES_LAT:1]             vld_pipe;
  logic [RES_LAT:1][TAG_W-1:0]  tag_pipe;

  // a requester granted this cycle is masked so a held req can't win twice in a row
  assign elig    = req & ~grant;
  assign tail_oh = NUM_REQ'(onehot(3'(tag_pipe[RES_LAT])));

  rr_picker #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) u_pick (
    .elig    (elig),
    .ptr     (ptr),
    .found   (found),
    .win_idx (win_idx),
    .win_oh  (win_oh)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant        <= '0;
      res_in       <= '0;
      res_in_valid <= 1'b0;
      res_tag      <= '0;
      ptr          <= '0;
      vld_pipe     <= '0;
      tag_pipe     <= '0;
      rsp_data     <= '0;
      rsp_valid    <= '0;
    end else begin
      if (found) begin
        grant        <= win_oh;
        res_in       <= req_data[win_idx*DATA_W +: DATA_W];
        res_in_valid <= 1'b1;
        res_tag      <= win_idx;
        ptr          <= (win_idx == TAG_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      end else begin
        grant        <= '0;
        res_in_valid <= 1'b0;
      end
      // stage 1 lines up with the cycle after res_in_valid; tail lines up with res_out
      vld_pipe[1] <= res_in_valid;
      tag_pipe[1] <= res_tag;
      for (int s = 2; s <= RES_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
      if (vld_pipe[RES_LAT]) begin
        rsp_data  <= res_out;
        rsp_valid <= tail_oh;
      end else begin
        rsp_valid <= '0;
      end
    end
  end
endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter with an operand+1, 2-cycle resource model.
module tb_resource_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   grant;
  logic [31:0]  res_in;
  logic         res_in_valid;
  logic [31:0]  res_out;
  logic [31:0]  rsp_data;
  logic [3:0]   rsp_valid;

  logic [31:0]  m1, m2, rnd;
  logic         tog;
  logic [31:0]  dat [4];
  int           n_chk, n_fail;

  resource_arbiter #(.NUM_REQ(4), .DATA_W(32), .RES_LAT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .res_in       (res_in),
    .res_in_valid (res_in_valid),
    .res_out      (res_out),
    .rsp_data     (rsp_data),
    .rsp_valid    (rsp_valid)
  );

  always #5 clk = ~clk;

  // resource model: result = operand + 1, two cycles after res_in_valid
  always @(posedge clk) begin
    m1  <= res_in + 32'd1;
    m2  <= m1;
    rnd <= $urandom;
  end
  assign res_out = tog ? rnd : m2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = dat[i];
  endtask

  int wexp [15];
  int ws, gcnt;

  initial begin
    n_chk = 0; n_fail = 0; tog = 1'b0;
    reset = 1'b0; req = '0;
    for (int i = 0; i < 4; i++) dat[i] = 32'h1000_0000 + i;
    load_data();
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_res_in", res_in, 0);
    chk("rst_riv", res_in_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ptr", dut.ptr, 0);
    step();
    reset = 1'b1;
    step();

    // all four requesting, then wrap-around from ptr=3 with req=1010, then idle
    wexp = '{-1, 0, 1, 2, 3, 0, 1, 2, 3, 1, -1, -1, -1, -1, -1};
    req = 4'b1111;
    for (int s = 1; s <= 14; s++) begin
      step();
      if (wexp[s] >= 0) begin
        chk($sformatf("rr_grant_%0d", s), grant, 64'(4'b1 << wexp[s]));
        chk($sformatf("rr_res_in_%0d", s), res_in, dat[wexp[s]]);
        chk($sformatf("rr_riv_%0d", s), res_in_valid, 1);
      end else begin
        chk($sformatf("idle_grant_%0d", s), grant, 0);
        chk($sformatf("idle_riv_%0d", s), res_in_valid, 0);
        chk($sformatf("idle_res_in_%0d", s), res_in, dat[1]);
      end
      ws = (s >= 4) ? wexp[s-3] : -1;
      chk($sformatf("rr_rsp_valid_%0d", s), rsp_valid, (ws < 0) ? 64'd0 : 64'(4'b1 << ws));
      if (ws >= 0) chk($sformatf("rr_rsp_data_%0d", s), rsp_data, dat[ws] + 32'd1);
      if (s == 7) chk("pre_wrap_ptr", dut.ptr, 3);
      if (s == 7) req = 4'b1010;
      if (s == 8) req = 4'b0010;
      if (s == 9) begin
        req = 4'b0000;
        chk("wrap_ptr", dut.ptr, 2);
      end
    end
    chk("idle_ptr", dut.ptr, 2);

    // single request from ptr=2: requester 0 wins, ptr moves to 1
    dat[0] = 32'hA5A5_0001; load_data();
    req = 4'b0001;
    step();
    chk("single_grant", grant, 4'b0001);
    chk("single_res_in", res_in, 32'hA5A5_0001);
    chk("single_ptr", dut.ptr, 1);
    req = 4'b0000;
    step();
    chk("single_grant_drop", grant, 0);
    chk("single_rsp_early1", rsp_valid, 0);
    step();
    chk("single_rsp_early2", rsp_valid, 0);
    step();
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_data", rsp_data, 32'hA5A5_0002);

    // requester 0 holds req for 6 cycles: grant every other cycle
    gcnt = 0;
    req = 4'b0001;
    for (int s = 0; s < 6; s++) begin
      step();
      chk($sformatf("hold_grant_%0d", s), grant[0], (s % 2 == 0) ? 1 : 0);
      if (grant[0]) gcnt++;
    end
    req = 4'b0000;
    chk("hold_grant_count", gcnt, 3);
    repeat (4) step();

    // reset with two operations in flight
    dat[0] = 32'h11; dat[1] = 32'h22; load_data();
    req = 4'b0011;
    step();
    chk("inflight_grant1", grant, 4'b0010);
    step();
    chk("inflight_grant0", grant, 4'b0001);
    req = 4'b0000;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_res_in", res_in, 0);
    chk("mid_rst_riv", res_in_valid, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_ptr", dut.ptr, 0);
    step();
    reset = 1'b1;
    tog = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("post_rst_rsp_valid_%0d", s), rsp_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
